// File: rtl/relay_link.sv
// rtl/relay_link.sv - Proxmark relay link: master round-trip timer, slave deframer, delay reporter
// One shared TX shifter serves both the SLAVE word and the DELAY report.
module relay_link #(
  parameter int unsigned       DIV_LOG2  = 4,
  parameter int unsigned       SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = 4'b1111,
  parameter int unsigned       PAYLOAD_W = 8,
  parameter int unsigned       DELAY_W   = 32,
  parameter int unsigned       HOLDOFF_W = 17
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic [1:0] mod_type,
  input  logic       data_in,
  output logic       data_out,
  input  logic       ssp_dout,
  output logic       ssp_din,
  output logic       ssp_frame,
  output logic       ssp_clk,
  output logic       delay_done
);

  localparam int SH_W  = (PAYLOAD_W > DELAY_W) ? PAYLOAD_W : DELAY_W;
  localparam int CNT_W = $clog2(SH_W + 1);

  localparam logic [1:0] MODE_MASTER = 2'b00;
  localparam logic [1:0] MODE_SLAVE  = 2'b01;
  localparam logic [1:0] MODE_DELAY  = 2'b10;
  localparam logic [1:0] MODE_IDLE   = 2'b11;

  typedef enum logic [1:0] {M_WAIT, M_COUNT, M_DONE} m_state_e;
  typedef enum logic {S_HUNT, S_PAYLOAD} r_state_e;
  typedef enum logic {T_IDLE, T_SHIFT} t_state_e;

  logic [1:0]           mode_q;
  logic [DIV_LOG2-1:0]  div_q;
  logic                 sync1_q, sync_in_q;
  m_state_e             m_state_q, m_state_d;
  r_state_e             r_state_q, r_state_d;
  t_state_e             t_state_q, t_state_d;
  logic [DELAY_W-1:0]   delay_count_q, delay_count_d;
  logic                 delay_done_q, delay_done_d;
  logic [SYNC_W-1:0]    window_q, window_d;
  logic [PAYLOAD_W-2:0] rx_sr_q, rx_sr_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [SH_W-1:0]      tx_sr_q, tx_sr_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
  logic                 ssp_din_q, ssp_din_d;
  logic                 ssp_frame_q, ssp_frame_d;
  logic                 data_out_q, data_out_d;

  logic                 tick, mode_chg, tx_load;
  logic [SYNC_W-1:0]    win_next;
  logic [PAYLOAD_W-1:0] rx_word;
  logic [SH_W-1:0]      tx_load_val;

  assign tick     = &div_q;
  assign mode_chg = (mod_type != mode_q);
  assign win_next = SYNC_W'({window_q, sync_in_q});
  assign rx_word  = {rx_sr_q, sync_in_q};

  always_comb begin
    m_state_d     = m_state_q;
    r_state_d     = r_state_q;
    t_state_d     = t_state_q;
    delay_count_d = delay_count_q;
    delay_done_d  = delay_done_q;
    window_d      = window_q;
    rx_sr_d       = rx_sr_q;
    rx_cnt_d      = rx_cnt_q;
    tx_sr_d       = tx_sr_q;
    tx_cnt_d      = tx_cnt_q;
    holdoff_d     = holdoff_q;
    ssp_din_d     = ssp_din_q;
    ssp_frame_d   = ssp_frame_q;
    data_out_d    = data_out_q;
    tx_load       = 1'b0;
    tx_load_val   = '0;

    // A mode switch or IDLE parks every FSM; the round-trip result survives.
    if (mode_chg || mode_q == MODE_IDLE) begin
      m_state_d   = M_WAIT;
      r_state_d   = S_HUNT;
      t_state_d   = T_IDLE;
      window_d    = '0;
      rx_cnt_d    = '0;
      tx_cnt_d    = '0;
      holdoff_d   = '0;
      ssp_din_d   = 1'b0;
      ssp_frame_d = 1'b0;
      data_out_d  = 1'b0;
    end else begin
      case (mode_q)
        MODE_MASTER: begin
          ssp_din_d   = 1'b0;
          ssp_frame_d = 1'b0;
          if (tick) data_out_d = ssp_dout;
          case (m_state_q)
            M_WAIT: if (tick && ssp_dout) begin
              delay_count_d = '0;
              delay_done_d  = 1'b0;
              m_state_d     = M_COUNT;
            end
            M_COUNT: begin
              if (delay_count_q != '1) delay_count_d = delay_count_q + 1'b1;
              if (sync_in_q) begin
                m_state_d    = M_DONE;
                delay_done_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
        MODE_SLAVE: if (tick) begin
          data_out_d = sync_in_q;
          case (r_state_q)
            S_HUNT: begin
              if (win_next == SYNC_PAT) begin
                r_state_d = S_PAYLOAD;
                window_d  = '0;
                rx_cnt_d  = '0;
              end else begin
                window_d = win_next;
              end
            end
            S_PAYLOAD: begin
              rx_sr_d = rx_word[PAYLOAD_W-2:0];
              if (rx_cnt_q == CNT_W'(PAYLOAD_W - 1)) begin
                r_state_d   = S_HUNT;
                tx_load     = 1'b1;
                tx_load_val = SH_W'(rx_word) << (SH_W - PAYLOAD_W);
              end else begin
                rx_cnt_d = rx_cnt_q + 1'b1;
              end
            end
          endcase
        end
        MODE_DELAY: begin
          data_out_d = 1'b0;
          if (tick && t_state_q == T_IDLE) begin
            holdoff_d = holdoff_q + 1'b1;
            if (holdoff_q == '1) begin
              tx_load     = 1'b1;
              tx_load_val = SH_W'(delay_count_q) << (SH_W - DELAY_W);
            end
          end
        end
        default: ;
      endcase

      // The first bit goes out on the load tick; one extra tick closes the word.
      if (tick) begin
        if (tx_load) begin
          ssp_din_d   = tx_load_val[SH_W-1];
          ssp_frame_d = 1'b1;
          tx_sr_d     = tx_load_val << 1;
          tx_cnt_d    = (mode_q == MODE_DELAY) ? CNT_W'(DELAY_W - 1) : CNT_W'(PAYLOAD_W - 1);
          t_state_d   = T_SHIFT;
        end else if (t_state_q == T_SHIFT) begin
          ssp_frame_d = 1'b0;
          if (tx_cnt_q == '0) begin
            ssp_din_d = 1'b0;
            t_state_d = T_IDLE;
            if (mode_q == MODE_DELAY) begin
              delay_done_d = 1'b0;
              m_state_d    = M_WAIT;
              holdoff_d    = '0;
            end
          end else begin
            ssp_din_d = tx_sr_q[SH_W-1];
            tx_sr_d   = tx_sr_q << 1;
            tx_cnt_d  = tx_cnt_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      mode_q        <= MODE_IDLE;
      div_q         <= '0;
      sync1_q       <= 1'b0;
      sync_in_q     <= 1'b0;
      m_state_q     <= M_WAIT;
      r_state_q     <= S_HUNT;
      t_state_q     <= T_IDLE;
      delay_count_q <= '0;
      delay_done_q  <= 1'b0;
      window_q      <= '0;
      rx_sr_q       <= '0;
      rx_cnt_q      <= '0;
      tx_sr_q       <= '0;
      tx_cnt_q      <= '0;
      holdoff_q     <= '0;
      ssp_din_q     <= 1'b0;
      ssp_frame_q   <= 1'b0;
      data_out_q    <= 1'b0;
    end else begin
      mode_q        <= mod_type;
      div_q         <= div_q + 1'b1;
      sync1_q       <= data_in;
      sync_in_q     <= sync1_q;
      m_state_q     <= m_state_d;
      r_state_q     <= r_state_d;
      t_state_q     <= t_state_d;
      delay_count_q <= delay_count_d;
      delay_done_q  <= delay_done_d;
      window_q      <= window_d;
      rx_sr_q       <= rx_sr_d;
      rx_cnt_q      <= rx_cnt_d;
      tx_sr_q       <= tx_sr_d;
      tx_cnt_q      <= tx_cnt_d;
      holdoff_q     <= holdoff_d;
      ssp_din_q     <= ssp_din_d;
      ssp_frame_q   <= ssp_frame_d;
      data_out_q    <= data_out_d;
    end
  end

  assign data_out   = data_out_q;
  assign ssp_din    = ssp_din_q;
  assign ssp_frame  = ssp_frame_q;
  assign ssp_clk    = (mode_q != MODE_IDLE) && div_q[DIV_LOG2-1];
  assign delay_done = delay_done_q;

endmodule

// File: tb/tb_relay_link.sv
// tb/tb_relay_link.sv - directed bench for relay_link
// Second instance with a 4-bit delay counter shares all inputs to exercise saturation.
module tb_relay_link;

  logic       clk;
  logic       reset;
  logic [1:0] mod_type;
  logic       data_in;
  logic       ssp_dout;
  logic       data_out, ssp_din, ssp_frame, ssp_clk, delay_done;
  logic       d4_data_out, d4_ssp_din, d4_ssp_frame, d4_ssp_clk, d4_delay_done;
  logic [3:0] tb_div;
  int         vectors;
  int         miscompares;
  logic [31:0] got;
  logic [11:0] v12;
  logic [15:0] v16;
  logic [7:0]  t8;
  logic [6:0]  v7;
  logic [31:0] word;

  relay_link #(.HOLDOFF_W(3)) u_dut (
    .ck_1356meg(clk), .reset(reset), .mod_type(mod_type), .data_in(data_in),
    .data_out(data_out), .ssp_dout(ssp_dout), .ssp_din(ssp_din),
    .ssp_frame(ssp_frame), .ssp_clk(ssp_clk), .delay_done(delay_done)
  );

  relay_link #(.DELAY_W(4), .HOLDOFF_W(3)) u_dut4 (
    .ck_1356meg(clk), .reset(reset), .mod_type(mod_type), .data_in(data_in),
    .data_out(d4_data_out), .ssp_dout(ssp_dout), .ssp_din(d4_ssp_din),
    .ssp_frame(d4_ssp_frame), .ssp_clk(d4_ssp_clk), .delay_done(d4_delay_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side divider: tb_div == 15 marks a tick cycle.
  always @(posedge clk) begin
    if (reset) tb_div <= 4'd0;
    else       tb_div <= tb_div + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lands in the cycle right after the next tick.
  task automatic next_bit();
    do @(negedge clk); while (tb_div != 4'hF);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic ef, input logic ed, input string tag);
    data_in = b;
    next_bit();
    chk({tag, "_dout"}, {31'd0, data_out}, {31'd0, b});
    chk({tag, "_frame"}, {31'd0, ssp_frame}, {31'd0, ef});
    chk({tag, "_din"}, {31'd0, ssp_din}, {31'd0, ed});
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    mod_type = 2'b00;
    data_in = 1'b0;
    ssp_dout = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", {31'd0, data_out}, 32'd0);
    chk("rst_din", {31'd0, ssp_din}, 32'd0);
    chk("rst_frame", {31'd0, ssp_frame}, 32'd0);
    chk("rst_clk", {31'd0, ssp_clk}, 32'd0);
    chk("rst_done", {31'd0, delay_done}, 32'd0);
    chk("rst_count", u_dut.delay_count_q, 32'd0);
    reset = 1'b0;

    // MASTER round trip: T0 is the tick cycle where ssp_dout=1 is sampled
    do @(negedge clk); while (tb_div != 4'hF);
    chk("m_clk_tick", {31'd0, ssp_clk}, 32'd1);
    chk("m_dout_pre", {31'd0, data_out}, 32'd0);
    ssp_dout = 1'b1;
    for (int k = 1; k <= 103; k++) begin
      @(negedge clk);
      if (k == 100) data_in = 1'b1;
      if (k == 1) begin
        chk("m_dout_fwd", {31'd0, data_out}, 32'd1);
        chk("m_clk_low", {31'd0, ssp_clk}, 32'd0);
        chk("m_frame", {31'd0, ssp_frame}, 32'd0);
      end
      if (k == 15) chk("m4_cnt_e", {28'd0, u_dut4.delay_count_q}, 32'hE);
      if (k == 17) chk("m4_cnt_sat", {28'd0, u_dut4.delay_count_q}, 32'hF);
      if (k == 40) begin
        chk("m4_cnt_hold", {28'd0, u_dut4.delay_count_q}, 32'hF);
        chk("m4_done", {31'd0, d4_delay_done}, 32'd0);
      end
      if (k == 102) chk("m_done_early", {31'd0, delay_done}, 32'd0);
      if (k == 103) begin
        chk("m_done", {31'd0, delay_done}, 32'd1);
        chk("m_count", u_dut.delay_count_q, 32'd102);
      end
    end

    // DELAY report of the 0x66 measurement, holdoff of 8 ticks
    next_bit();
    data_in = 1'b0;
    ssp_dout = 1'b0;
    mod_type = 2'b10;
    repeat (7) next_bit();
    chk("d_holdoff", {31'd0, ssp_frame}, 32'd0);
    next_bit();
    word = 32'h0000_0066;
    got = 32'd0;
    for (int j = 31; j >= 0; j--) begin
      if (j != 31) next_bit();
      chk("d_frame", {31'd0, ssp_frame}, {31'd0, (j == 31)});
      chk("d_bit", {31'd0, ssp_din}, {31'd0, word[j]});
      got = {got[30:0], ssp_din};
      if (j == 0) chk("d_done_last", {31'd0, delay_done}, 32'd1);
    end
    chk("d_word", got, 32'h0000_0066);
    next_bit();
    chk("d_end_din", {31'd0, ssp_din}, 32'd0);
    chk("d_end_frame", {31'd0, ssp_frame}, 32'd0);
    chk("d_end_done", {31'd0, delay_done}, 32'd0);
    chk("d_data_out", {31'd0, data_out}, 32'd0);
    repeat (8) next_bit();
    chk("d_rearm", {31'd0, ssp_frame}, 32'd1);
    repeat (25) next_bit();
    chk("d_bit6", {31'd0, ssp_din}, 32'd1);

    // reset in the middle of the report
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("r_frame", {31'd0, ssp_frame}, 32'd0);
    chk("r_din", {31'd0, ssp_din}, 32'd0);
    chk("r_clk", {31'd0, ssp_clk}, 32'd0);
    chk("r_count", u_dut.delay_count_q, 32'd0);
    chk("r_done", {31'd0, delay_done}, 32'd0);

    // SLAVE: sync 1111 + 0xA5
    mod_type = 2'b01;
    @(negedge clk);
    reset = 1'b0;
    next_bit();
    v12 = 12'b1111_1010_0101;
    for (int i = 11; i >= 0; i--) send_bit(v12[i], (i == 0), (i == 0), "s3_rx");
    t8 = 8'b0100_1010;
    for (int i = 7; i >= 0; i--) send_bit(1'b0, 1'b0, t8[i], "s3_tx");

    // SLAVE: partial 111 ignored, then sync + 0x3C
    v16 = 16'b1110_1111_0011_1100;
    for (int i = 15; i >= 0; i--) send_bit(v16[i], (i == 0), 1'b0, "s4_rx");
    t8 = 8'b0111_1000;
    for (int i = 7; i >= 0; i--) send_bit(1'b0, 1'b0, t8[i], "s4_tx");

    // SLAVE: mode change mid payload discards the word
    v7 = 7'b1111_101;
    for (int i = 6; i >= 0; i--) send_bit(v7[i], 1'b0, 1'b0, "s6_rx");
    data_in = 1'b0;
    mod_type = 2'b11;
    repeat (12) @(negedge clk);
    chk("i_clk", {31'd0, ssp_clk}, 32'd0);
    chk("i_dout", {31'd0, data_out}, 32'd0);
    next_bit();
    mod_type = 2'b01;
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b0, 1'b0, "s6_discard");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
